// File: rtl/srl2prl_pkg.sv
// -----------------------------------------------------------------------------
// srl2prl_pkg
//   Shared definitions for the serial-to-parallel receiver and its matching
//   parallel-to-serial transmitter.
//
//   Contents:
//     DEFAULT_DATA_W     default word width (must agree with the transmitter)
//     DEFAULT_FIFO_DEPTH default receive FIFO depth
//     IDLE / RECV        receiver FSM state encoding
//     at_least_one()     clamps a derived width so it never collapses to zero
// -----------------------------------------------------------------------------
package srl2prl_pkg;

    localparam int unsigned DEFAULT_DATA_W     = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    // $clog2(1) is 0, which would give a zero-width vector.
    function automatic int unsigned at_least_one(input int unsigned v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/srl2prl_fifo.sv
// -----------------------------------------------------------------------------
// srl2prl_fifo
//   Synchronous FIFO holding completed receive words.
//
//   Ports:
//     clock    in   rising-edge clock
//     rst      in   asynchronous active-high reset
//     wr_en    in   request to push wr_data
//     wr_data  in   WIDTH-bit word to push
//     full     out  FIFO holds DEPTH entries
//     rd_en    in   pop the head entry (ignored when empty)
//     rd_data  out  head entry, forced to 0 while empty
//     empty    out  FIFO holds no entries
//     level    out  occupancy, 0..DEPTH
//
//   A push while full is accepted when a pop happens on the same edge.
// -----------------------------------------------------------------------------
module srl2prl_fifo
    import srl2prl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_W,
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = at_least_one($clog2(DEPTH));
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_rd, do_wr;

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LEVEL);

    assign do_rd = rd_en && !empty;
    // A pop on the same edge frees the slot the push needs.
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // DEPTH is a power of two, so the pointers wrap by plain overflow.
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are unreachable
    // because occupancy is reset and rd_data is masked while empty.
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/srl2prl.sv
// -----------------------------------------------------------------------------
// srl2prl
//   Serial-to-parallel receiver. Samples srl MSB-first on every clock with
//   valid high, assembles DATA_W-bit words and queues them in a small FIFO
//   read through a valid/ready handshake.
//
//   Ports:
//     clock      in   rising-edge clock
//     rst        in   asynchronous active-high reset
//     srl        in   serial data bit, MSB first
//     valid      in   srl carries a data bit this cycle
//     prl        out  head-of-FIFO word (0 while empty)
//     prl_valid  out  FIFO not empty
//     prl_ready  in   consumer takes prl when prl_valid && prl_ready
//     level      out  FIFO occupancy, 0..FIFO_DEPTH
//     frame_err  out  one-cycle pulse: frame aborted after 1..DATA_W-1 bits
//     overrun    out  one-cycle pulse: completed word dropped, FIFO full
// -----------------------------------------------------------------------------
module srl2prl
    import srl2prl_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned CNT_W      = $clog2(DATA_W)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          srl,
    input  logic                          valid,
    output logic [DATA_W-1:0]             prl,
    output logic                          prl_valid,
    input  logic                          prl_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int unsigned     CW       = at_least_one(CNT_W);
    localparam int unsigned     SH_W     = at_least_one(DATA_W - 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] word;
    logic [SH_W-1:0]   sh_shift;
    logic              word_done;
    logic              fifo_full, fifo_empty, fifo_rd;

    // Only the low DATA_W-1 bits need storing: the final bit arrives live on
    // srl and the word is pushed straight into the FIFO on that edge.
    if (DATA_W == 1) begin : g_w1
        assign word     = srl;
        assign sh_shift = '0;
    end else begin : g_wn
        assign word     = {sh_q, srl};
        assign sh_shift = word[DATA_W-2:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;
        case (state_q)
            IDLE, RECV: begin
                if (valid) begin
                    sh_d = sh_shift;
                    // In IDLE cnt_q is 0, so DATA_W=1 completes right here.
                    if (cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = RECV;
                    end
                end else if (state_q == RECV) begin
                    // Partial word: discard it and flag the abort.
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    sh_d        = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_rd   = prl_valid && prl_ready;
    // A read on the completing edge makes room, so only a full FIFO with no
    // read drops the word.
    assign overrun_d = word_done && fifo_full && !fifo_rd;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    srl2prl_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (word_done),
        .wr_data (word),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (prl),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign prl_valid = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_srl2prl.sv
// -----------------------------------------------------------------------------
// tb_srl2prl
//   Directed self-checking bench for srl2prl (DATA_W=8, FIFO_DEPTH=4).
//   Inputs change 1 time unit after a rising edge; a monitor samples the
//   handshake and pulse outputs on the falling edge.
// -----------------------------------------------------------------------------
module tb_srl2prl;

    logic       clock;
    logic       rst;
    logic       srl;
    logic       valid;
    logic [7:0] prl;
    logic       prl_valid;
    logic       prl_ready;
    logic [2:0] level;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    srl2prl #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .srl       (srl),
        .valid     (valid),
        .prl       (prl),
        .prl_valid (prl_valid),
        .prl_ready (prl_ready),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Accepted words and pulse counts, sampled mid-cycle.
    always @(negedge clock) begin
        if (!rst) begin
            if (prl_valid && prl_ready) rx_q.push_back(prl);
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        srl   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            srl   = w[i];
            valid = 1'b1;
            tick();
        end
    endtask

    // Compares everything the monitor collected against exp_q, then clears both.
    task automatic check_rx(input string tag);
        logic [31:0] got;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD;
            check($sformatf("%s_w%0d", tag, i), got, {24'h0, exp_q[i]});
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        srl       = 1'b0;
        valid     = 1'b0;
        prl_ready = 1'b0;
        #1;
        check("rst_prl",       prl,       0);
        check("rst_prl_valid", prl_valid, 0);
        check("rst_level",     level,     0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun",   overrun,   0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1. single word A5
        prl_ready = 1'b1;
        send_word(8'hA5);
        check("t1_prl_valid", prl_valid, 1);
        check("t1_prl",       prl,       8'hA5);
        check("t1_level_1",   level,     1);
        idle(2);
        check("t1_level_0",   level,     0);
        exp_q.push_back(8'hA5);
        check_rx("t1_rx");
        check("t1_fe", fe_cnt, 0);
        check("t1_ov", ov_cnt, 0);

        // 2. transmitter pattern with gaps, then continuous
        send_word(8'h3C); idle(1);
        send_word(8'hC3); idle(1);
        send_word(8'hFF); idle(1);
        send_word(8'h00); idle(3);
        exp_q = '{8'h3C, 8'hC3, 8'hFF, 8'h00};
        check_rx("t2_gap");
        send_word(8'h3C);
        send_word(8'hC3);
        send_word(8'hFF);
        send_word(8'h00);
        idle(3);
        exp_q = '{8'h3C, 8'hC3, 8'hFF, 8'h00};
        check_rx("t2_cont");
        check("t2_fe", fe_cnt, 0);

        // 3. abort after 5 bits of F0
        for (int i = 7; i >= 3; i--) begin
            srl   = (i >= 4);
            valid = 1'b1;
            tick();
        end
        valid = 1'b0;
        tick();
        check("t3_fe_hi", frame_err, 1);
        tick();
        check("t3_fe_lo", frame_err, 0);
        check("t3_level", level, 0);
        send_word(8'h81);
        idle(3);
        exp_q.push_back(8'h81);
        check_rx("t3_rx");
        check("t3_fe_cnt", fe_cnt, 1);

        // 4. overrun with prl_ready low
        prl_ready = 1'b0;
        send_word(8'h01); idle(1);
        send_word(8'h02); idle(1);
        send_word(8'h03); idle(1);
        send_word(8'h04);
        check("t4_level_4", level, 4);
        check("t4_no_ov", overrun, 0);
        idle(1);
        send_word(8'h05);
        check("t4_ov_hi", overrun, 1);
        idle(1);
        check("t4_ov_lo", overrun, 0);
        check("t4_level_kept", level, 4);
        check("t4_head", prl, 8'h01);
        prl_ready = 1'b1;
        idle(6);
        check("t4_level_0", level, 0);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_rx("t4_rx");
        check("t4_ov_cnt", ov_cnt, 1);

        // 5. full FIFO, completing word coincides with a read
        prl_ready = 1'b0;
        send_word(8'h01); idle(1);
        send_word(8'h02); idle(1);
        send_word(8'h03); idle(1);
        send_word(8'h04); idle(1);
        check("t5_level_full", level, 4);
        for (int i = 7; i >= 1; i--) begin
            srl   = ((8'h55 >> i) & 8'h01) != 0;
            valid = 1'b1;
            tick();
        end
        srl       = 1'b1;
        prl_ready = 1'b1;
        tick();
        check("t5_no_ov", overrun, 0);
        check("t5_level", level, 4);
        check("t5_head",  prl, 8'h02);
        idle(6);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
        check_rx("t5_rx");
        check("t5_ov_cnt", ov_cnt, 1);

        // 6. asynchronous reset mid-frame with two words queued
        prl_ready = 1'b0;
        send_word(8'h11); idle(1);
        send_word(8'h22); idle(1);
        check("t6_level_2", level, 2);
        srl = 1'b0; valid = 1'b1; tick();
        srl = 1'b1; tick();
        srl = 1'b0; tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_prl",       prl,       0);
        check("t6_prl_valid", prl_valid, 0);
        check("t6_level",     level,     0);
        check("t6_fe",        frame_err, 0);
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t6_fe_after", frame_err, 0);
        prl_ready = 1'b1;
        send_word(8'h5A);
        check("t6_prl_5a", prl, 8'h5A);
        idle(3);
        exp_q.push_back(8'h5A);
        check_rx("t6_rx");
        check("t6_fe_cnt", fe_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srl2prl.md
Name: srl2prl

Overview:
- Serial-to-parallel receiver; the receive end of the 1-bit serial link driven by the parallel-to-serial transmitter.
- Samples `srl` MSB-first on every clock where `valid` is high and assembles DATA_W-bit words.
- Completed words go into a small output FIFO, read through a valid/ready handshake.
- Reports frame aborts (partial words) and overruns (word completed while the FIFO is full).

Parameters:
- DATA_W, 8, word width in bits; must match the transmitter.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DATA_W), width of the bit counter.

Ports:
- clock  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- srl  input  1  serial data, MSB first.
- valid  input  1  high = `srl` carries a data bit this cycle.
- prl  output  DATA_W  head-of-FIFO word.
- prl_valid  output  1  FIFO not empty; `prl` is meaningful.
- prl_ready  input  1  consumer accepts `prl` when prl_valid && prl_ready.
- level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.
- frame_err  output  1  one-cycle pulse: frame aborted with 1..DATA_W-1 bits received.
- overrun  output  1  one-cycle pulse: completed word dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, bit count=0, shift register=0, FIFO empty.
  - Outputs: prl=0, prl_valid=0, level=0, frame_err=0, overrun=0.
  - A reset mid-frame discards the partial word. No frame_err is raised for it.
- FSM:
  - IDLE: valid=1 shifts in the first bit and moves to RECV with count=1. With DATA_W=1 the word completes immediately and the FSM stays in IDLE. valid=0 stays in IDLE.
  - RECV, valid=1: shift `{sh[DATA_W-2:0], srl}` and increment count.
  - RECV, valid=1 on the bit that makes count==DATA_W: the word is complete. Count goes to 0 and the FSM returns to IDLE.
  - RECV, valid=0: the frame is aborted. frame_err pulses on the next cycle, count goes to 0, the FSM returns to IDLE, and the partial bits are discarded.
- Back-to-back frames:
  - valid may stay high continuously across word boundaries.
  - The cycle after completion is IDLE with valid=1, so it is treated as bit 0 of the next word.
  - There is no dead cycle and no lost bit.
  - A one-cycle valid gap between frames (the normal transmitter pattern) is legal and raises no error.
- Word completion:
  - The assembled word is `{sh[DATA_W-2:0], srl}`, written into the FIFO on the same edge as the final bit.
  - prl_valid rises on the following cycle. Latency is 1 clock from the last bit sample to prl_valid.
- FIFO:
  - Write when a word completes and the FIFO is not full.
  - Read when prl_valid && prl_ready.
  - Simultaneous read and write while full: the read frees a slot, so the write is accepted and level is unchanged.
  - Simultaneous read and write while empty: not possible, since prl_valid=0.
  - Full with no read on the completing cycle: the word is dropped, overrun pulses on the next cycle, and stored entries are untouched.
  - Pointers wrap modulo FIFO_DEPTH.
  - `prl` is driven from the head entry and holds stable while prl_valid=1 and prl_ready=0.
- Pulse timing:
  - frame_err and overrun are registered, high exactly one cycle per event, and independent of each other.
- Input conditioning:
  - srl and valid are synchronous to `clock`; no synchronizer is included.

Decomposition:
- Shared package srl2prl_pkg:
  - State encoding: IDLE=1'b0, RECV=1'b1.
  - Default DATA_W and FIFO_DEPTH constants, also used by the transmitter.
- Natural sub-module: srl2prl_fifo, a synchronous FIFO with parameters WIDTH/DEPTH.
  - Ports: wr_en/wr_data/full, rd_en/rd_data/empty, level.
  - Asynchronous active-high reset on the same `rst`.
- Top level holds the FSM, bit counter, shift register, pulse registers and FIFO instance.

Test Plan:
1. Single word: valid=1 for 8 cycles with srl=1,0,1,0,0,1,0,1 and prl_ready=1.
   - prl_valid pulses 1 cycle after the last bit with prl=8'hA5; level returns to 0.
   - No frame_err, no overrun.
2. Transmitter pattern: words 8'h3C, 8'hC3, 8'hFF, 8'h00 with a 1-cycle valid gap between them; then repeat with valid high continuously for 32 cycles.
   - Four words in order each time.
   - frame_err never asserts.
3. Abort: 5 bits of 8'hF0 followed by valid=0.
   - frame_err high exactly 1 cycle.
   - Next full frame of 8'h81 delivers prl=8'h81; the FIFO never holds a partial word.
4. Overrun: prl_ready=0, send 5 words 8'h01..8'h05.
   - level=4 after the 4th word; overrun pulses once on the 5th.
   - Raising prl_ready then drains 01,02,03,04; 05 is lost.
5. Full with simultaneous read: FIFO full; complete a 5th word 8'h55 on the same cycle prl_ready=1.
   - No overrun; level stays 4.
   - Drain order is 02,03,04,55.
6. Reset mid-frame and mid-FIFO: rst=1 asynchronously after 3 bits with 2 words queued.
   - Outputs go to 0 immediately: prl=0, prl_valid=0, level=0.
   - No frame_err.
   - After release, the first complete frame 8'h5A is received correctly.
